ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with a 2-entry prefetch buffer.
//
// Keeps the fetch PC, issues at most one instruction-memory request at a
// time, buffers up to two returned {pc, instr} pairs for decode, and handles
// redirects. A redirect that arrives while a request is still unacked leaves
// that request on the bus until its ack, then throws the data away.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   imem_req     memory request valid
//   imem_addr    word-aligned request address
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word, valid with imem_ack
//   redirect     branch/jump resolution changes the PC
//   redirect_pc  new fetch target, bits [1:0] ignored
//   instr_valid  buffer head is valid
//   instr        buffer head instruction (0 when empty)
//   instr_pc     buffer head address (0 when empty)
//   instr_ready  decode consumes the head this cycle
//
// state | meaning
// REQ   | free to issue a request at fpc when buffer has room
// WAIT  | request at hold_addr outstanding, result will be kept
// DROP  | stale request outstanding after redirect, result discarded
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] hold_addr;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] buf_pc  [2];
  logic [31:0] buf_ins [2];

  logic ack_c;
  logic push;
  logic pop;

  always_comb begin
    // Once issued, a request stays up regardless of redirect or buffer state;
    // a new one only issues with room in the buffer and no redirect pending.
    imem_req    = reset & ((state != S_REQ) | ((count <= 2'd1) & ~redirect));
    imem_addr   = (state == S_REQ) ? fpc : hold_addr;
    ack_c       = imem_req & imem_ack;
    push        = ack_c & ~redirect & (state != S_DROP);
    pop         = (count != 2'd0) & instr_ready & ~redirect;
    instr_valid = (count != 2'd0);
    instr       = instr_valid ? buf_ins[rd_ptr] : 32'h0;
    instr_pc    = instr_valid ? buf_pc[rd_ptr]  : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      fpc       <= RESET_PC;
      hold_addr <= 32'h0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]  <= 32'h0;
        buf_ins[i] <= 32'h0;
      end
    end else if (redirect) begin
      fpc    <= redirect_pc & ~32'h3;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      // In REQ the redirect itself suppresses issue, so only WAIT/DROP can
      // have a request that is still waiting for its ack.
      state  <= (imem_req & ~ack_c) ? S_DROP : S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (ack_c) begin
            fpc <= fpc + 32'd4;
          end else if (imem_req) begin
            hold_addr <= fpc;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_c) begin
            fpc   <= fpc + 32'd4;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (ack_c) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (push) begin
        buf_pc[wr_ptr]  <= imem_addr;
        buf_ins[wr_ptr] <= imem_rdata;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
